// File: rtl/data_sync_pulse.sv
// Enable-qualified bus synchroniser into the CLK domain.
// Emits a one-cycle pulse per synchronised enable event and counts transfers.
module data_sync_pulse #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int MODE       = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 DATA_ERR,
    output logic [CNT_WIDTH-1:0] EVENT_CNT
);

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  en_prev_q, en_prev_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
    logic                  pulse_q, pulse_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  en_s;
    logic                  evt;

    assign en_s = sync_q[NUM_STAGES-1];

    // Event detect on the synchronised enable: rising edge or any edge.
    always_comb begin
        evt = 1'b0;
        if (MODE == 1) begin
            evt = en_s ^ en_prev_q;
        end else begin
            evt = en_s & ~en_prev_q;
        end
    end

    // Next-state: shift chain, bus history, capture and count on event.
    always_comb begin
        sync_d     = {sync_q[NUM_STAGES-2:0], BUS_EN};
        en_prev_d  = en_s;
        bus_d      = UNSYNC_BUS;
        sync_bus_d = sync_bus_q;
        pulse_d    = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        if (evt) begin
            sync_bus_d = UNSYNC_BUS;
            pulse_d    = 1'b1;
            err_d      = (UNSYNC_BUS != bus_q);
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q     <= '0;
            en_prev_q  <= 1'b0;
            bus_q      <= '0;
            sync_bus_q <= '0;
            pulse_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            en_prev_q  <= en_prev_d;
            bus_q      <= bus_d;
            sync_bus_q <= sync_bus_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign SYNC_BUS     = sync_bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign DATA_ERR     = err_q;
    assign EVENT_CNT    = cnt_q;

endmodule

// File: tb/tb_data_sync_pulse.sv
// Scoreboard bench: instance A is LEVEL/2 stages/8-bit count,
// instance B is TOGGLE/4 stages/2-bit saturating count.
module tb_data_sync_pulse;

    typedef struct {
        logic [7:0] bus;
        logic       err;
        int         cnt;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       rst_a, en_a, pulse_a, derr_a;
    logic [7:0] bus_a, sb_a, cnt_a;
    logic       rst_b, en_b, pulse_b, derr_b;
    logic [7:0] bus_b, sb_b;
    logic [1:0] cnt_b;

    exp_t qa[$];
    exp_t qb[$];
    int   mcnt_a = 0;
    int   mcnt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    data_sync_pulse #(.NUM_STAGES(2), .BUS_WIDTH(8), .MODE(0), .CNT_WIDTH(8)) u_a (
        .CLK(clk), .RST(rst_a), .UNSYNC_BUS(bus_a), .BUS_EN(en_a),
        .SYNC_BUS(sb_a), .ENABLE_PULSE(pulse_a), .DATA_ERR(derr_a),
        .EVENT_CNT(cnt_a)
    );

    data_sync_pulse #(.NUM_STAGES(4), .BUS_WIDTH(8), .MODE(1), .CNT_WIDTH(2)) u_b (
        .CLK(clk), .RST(rst_b), .UNSYNC_BUS(bus_b), .BUS_EN(en_b),
        .SYNC_BUS(sb_b), .ENABLE_PULSE(pulse_b), .DATA_ERR(derr_b),
        .EVENT_CNT(cnt_b)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    // Expected pulse for A: lat edges after the current cycle.
    task automatic push_a(input logic [7:0] b, input logic e, input int lat);
        exp_t x;
        if (mcnt_a < 255) mcnt_a++;
        x.bus = b; x.err = e; x.cnt = mcnt_a; x.cyc = cyc + lat;
        qa.push_back(x);
    endtask

    task automatic push_b(input logic [7:0] b, input logic e, input int lat);
        exp_t x;
        if (mcnt_b < 3) mcnt_b++;
        x.bus = b; x.err = e; x.cnt = mcnt_b; x.cyc = cyc + lat;
        qb.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops an expectation for every pulse seen on either instance.
    always @(negedge clk) begin
        exp_t x;
        if (pulse_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", 1, 0);
            end else begin
                x = qa.pop_front();
                chk("a_sync_bus", int'(sb_a), int'(x.bus));
                chk("a_data_err", int'(derr_a), int'(x.err));
                chk("a_event_cnt", int'(cnt_a), x.cnt);
                chk("a_pulse_cycle", cyc, x.cyc);
            end
        end else if (derr_a) begin
            chk("a_err_without_pulse", 1, 0);
        end
        if (pulse_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", 1, 0);
            end else begin
                x = qb.pop_front();
                chk("b_sync_bus", int'(sb_b), int'(x.bus));
                chk("b_data_err", int'(derr_b), int'(x.err));
                chk("b_event_cnt", int'(cnt_b), x.cnt);
                chk("b_pulse_cycle", cyc, x.cyc);
            end
        end else if (derr_b) begin
            chk("b_err_without_pulse", 1, 0);
        end
    end

    initial begin
        logic nv;
        rst_a = 1'b1; rst_b = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        bus_a = 8'h00; bus_b = 8'h00;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        wait_cyc(3);
        chk("rst_sync_bus", int'(sb_a), 0);
        chk("rst_pulse", int'(pulse_a), 0);
        chk("rst_err", int'(derr_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        rst_a = 1'b1;
        wait_cyc(3);

        // T1: level, single pulse after edge 3, held high 20 cycles.
        bus_a = 8'hA5; en_a = 1'b1;
        push_a(8'hA5, 1'b0, 3);
        wait_cyc(20);
        en_a = 1'b0;
        wait_cyc(5);

        // T3: bus changes just before the capture edge.
        bus_a = 8'h3C;
        wait_cyc(2);
        en_a = 1'b1;
        wait_cyc(2);
        bus_a = 8'hC3;
        push_a(8'hC3, 1'b1, 1);
        wait_cyc(6);
        en_a = 1'b0;
        wait_cyc(5);
        bus_a = 8'h77; en_a = 1'b1;
        push_a(8'h77, 1'b0, 3);
        wait_cyc(6);
        en_a = 1'b0;
        wait_cyc(5);

        // T4: reset mid-chain, then release with enable still high.
        bus_a = 8'h11; en_a = 1'b1;
        wait_cyc(1);
        rst_a = 1'b0;
        #1;
        chk("t4_sync_bus", int'(sb_a), 0);
        chk("t4_cnt", int'(cnt_a), 0);
        chk("t4_pulse", int'(pulse_a), 0);
        chk("t4_err", int'(derr_a), 0);
        mcnt_a = 0;
        wait_cyc(3);
        rst_a = 1'b1;
        push_a(8'h11, 1'b0, 3);
        wait_cyc(10);
        en_a = 1'b0;
        wait_cyc(5);

        // B: 4-stage toggle; latency, sequence and saturation.
        rst_b = 1'b1;
        wait_cyc(3);
        bus_b = 8'hA5; en_b = 1'b1;
        push_b(8'hA5, 1'b0, 5);
        wait_cyc(10);
        for (int i = 1; i <= 5; i++) begin
            bus_b = 8'(i);
            en_b = ~en_b;
            push_b(8'(i), 1'b0, 5);
            wait_cyc(5);
        end
        wait_cyc(6);
        chk("b_cnt_saturated", int'(cnt_b), 3);

        // Jitter: every change of the sampled enable is one event.
        bus_b = 8'h5A;
        wait_cyc(8);
        for (int i = 0; i < 200; i++) begin
            nv = 1'($urandom_range(0, 1));
            if (nv != en_b) push_b(8'h5A, 1'b0, 5);
            en_b = nv;
            wait_cyc(1);
        end
        wait_cyc(10);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
